// File: rtl/stat_scanner_if.sv
// Bus bundle between the stats sweeper and its environment: sweep control,
// the read-and-clear port toward the stats RAM, and the result stream.
interface stat_scanner_if #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32
);
  logic                       start_i;
  logic [A_WIDTH-1:0]         first_flow_i;
  logic [A_WIDTH-1:0]         last_flow_i;
  logic                       busy_o;
  logic                       rd_stb_o;
  logic [A_WIDTH-1:0]         rd_flow_num_o;
  logic [D_WIDTH-1:0]         rd_data_i;
  logic                       rd_data_val_i;
  logic                       out_valid_o;
  logic                       out_ready_i;
  logic [A_WIDTH-1:0]         out_flow_o;
  logic [D_WIDTH-1:0]         out_data_o;
  logic                       out_err_o;
  logic [D_WIDTH+A_WIDTH-1:0] total_o;
  logic                       done_o;

  modport master (
    input  start_i, first_flow_i, last_flow_i,
    input  rd_data_i, rd_data_val_i, out_ready_i,
    output busy_o, rd_stb_o, rd_flow_num_o,
    output out_valid_o, out_flow_o, out_data_o, out_err_o,
    output total_o, done_o
  );

  modport slave (
    output start_i, first_flow_i, last_flow_i,
    output rd_data_i, rd_data_val_i, out_ready_i,
    input  busy_o, rd_stb_o, rd_flow_num_o,
    input  out_valid_o, out_flow_o, out_data_o, out_err_o,
    input  total_o, done_o
  );
endinterface

// File: rtl/stat_scanner.sv
// Sweeps a (possibly wrapping) range of flow counters: read-and-clear each one,
// stream (flow, value) beats downstream and accumulate a sweep total.
module stat_scanner #(
  parameter int A_WIDTH = 10,
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 15
) (
  input logic            clk_i,
  input logic            rst_i,
  stat_scanner_if.master bus
);
  localparam int T_WIDTH = 8;
  localparam int S_WIDTH = D_WIDTH + A_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_PUSH,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [A_WIDTH-1:0]   cur_q, cur_d;
  logic [A_WIDTH-1:0]   last_q, last_d;
  logic [T_WIDTH-1:0]   timer_q, timer_d;
  logic                 busy_q, busy_d;
  logic                 rd_stb_q, rd_stb_d;
  logic                 out_valid_q, out_valid_d;
  logic [A_WIDTH-1:0]   out_flow_q, out_flow_d;
  logic [D_WIDTH-1:0]   out_data_q, out_data_d;
  logic                 out_err_q, out_err_d;
  logic [S_WIDTH-1:0]   total_q, total_d;
  logic                 done_q, done_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cur_q       <= '0;
      last_q      <= '0;
      timer_q     <= '0;
      busy_q      <= 1'b0;
      rd_stb_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_flow_q  <= '0;
      out_data_q  <= '0;
      out_err_q   <= 1'b0;
      total_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      last_q      <= last_d;
      timer_q     <= timer_d;
      busy_q      <= busy_d;
      rd_stb_q    <= rd_stb_d;
      out_valid_q <= out_valid_d;
      out_flow_q  <= out_flow_d;
      out_data_q  <= out_data_d;
      out_err_q   <= out_err_d;
      total_q     <= total_d;
      done_q      <= done_d;
    end
  end

  // Outputs are computed one state ahead so every port comes straight from a flop.
  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    last_d      = last_q;
    timer_d     = timer_q;
    busy_d      = busy_q;
    rd_stb_d    = 1'b0;
    out_valid_d = out_valid_q;
    out_flow_d  = out_flow_q;
    out_data_d  = out_data_q;
    out_err_d   = out_err_q;
    total_d     = total_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.start_i) begin
          cur_d    = bus.first_flow_i;
          last_d   = bus.last_flow_i;
          total_d  = '0;
          busy_d   = 1'b1;
          rd_stb_d = 1'b1;
          state_d  = S_REQ;
        end
      end
      S_REQ: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.rd_data_val_i) begin
          out_data_d  = bus.rd_data_i;
          out_err_d   = 1'b0;
          out_flow_d  = cur_q;
          out_valid_d = 1'b1;
          state_d     = S_PUSH;
        end else if (timer_q == T_WIDTH'(TIMEOUT - 1)) begin
          // TIMEOUT silent WAIT cycles elapsed: emit a zero beat flagged as error
          out_data_d  = '0;
          out_err_d   = 1'b1;
          out_flow_d  = cur_q;
          out_valid_d = 1'b1;
          state_d     = S_PUSH;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_PUSH: begin
        if (bus.out_ready_i) begin
          out_valid_d = 1'b0;
          total_d     = total_q + S_WIDTH'(out_data_q);
          if (cur_q == last_q) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cur_d    = cur_q + 1'b1;
            rd_stb_d = 1'b1;
            state_d  = S_REQ;
          end
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.busy_o        = busy_q;
  assign bus.rd_stb_o      = rd_stb_q;
  assign bus.rd_flow_num_o = cur_q;
  assign bus.out_valid_o   = out_valid_q;
  assign bus.out_flow_o    = out_flow_q;
  assign bus.out_data_o    = out_data_q;
  assign bus.out_err_o     = out_err_q;
  assign bus.total_o       = total_q;
  assign bus.done_o        = done_q;
endmodule

// File: tb/tb_stat_scanner.sv
// Directed + randomized sweeps against a per-flow responder table and a
// range/sum reference model; a monitor checks handshake and hold rules.
module tb_stat_scanner;
  localparam int AW = 4;
  localparam int DW = 32;
  localparam int TO = 15;

  typedef struct {
    logic [AW-1:0] flow;
    logic [DW-1:0] data;
    logic          err;
    int            lat;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stat_scanner_if #(.A_WIDTH(AW), .D_WIDTH(DW)) bus ();
  stat_scanner #(.A_WIDTH(AW), .D_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // responder table, written by the main sequence
  int          dly[16];
  bit          silent[16];
  logic [DW-1:0] rdat[16];
  int          rdy_mode = 0;
  int          hold = 0;

  // stats RAM responder: answers dly[] cycles after the strobe, junk otherwise
  initial begin : responder
    int cnt;
    logic [AW-1:0] pf;
    cnt = 0;
    pf  = '0;
    bus.rd_data_val_i = 1'b0;
    bus.rd_data_i     = '0;
    forever begin
      @(posedge clk); #1;
      bus.rd_data_val_i = 1'b0;
      bus.rd_data_i     = $urandom;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          bus.rd_data_val_i = 1'b1;
          bus.rd_data_i     = rdat[pf];
        end
      end else if (bus.out_valid_o && $urandom_range(0, 2) == 0) begin
        bus.rd_data_val_i = 1'b1;  // stray valid while holding a beat
      end
      if (bus.rd_stb_o) begin
        pf = bus.rd_flow_num_o;
        if (!silent[pf]) cnt = dly[pf];
      end
    end
  end

  initial begin : ready_gen
    bus.out_ready_i = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1: bus.out_ready_i = ($urandom_range(0, 2) != 0);
        2: if (bus.out_valid_o && bus.out_flow_o == 4'd4 && hold < 4) begin
             bus.out_ready_i = 1'b0;
             hold++;
           end else bus.out_ready_i = 1'b1;
        default: bus.out_ready_i = 1'b1;
      endcase
    end
  end

  // monitor
  beat_t got_q[$];
  int    stb_q[$];
  int    done_cnt = 0;
  int    cyc = 0;
  int    stb_cyc = 0;
  bit    outstanding = 0;
  bit    pend = 0;
  beat_t held;

  always @(negedge clk) begin
    cyc++;
    if (rst !== 1'b0) begin
      outstanding = 0;
      pend = 0;
    end else begin
      if (bus.rd_stb_o) begin
        chk("single_outstanding", 64'(outstanding), 64'd0);
        outstanding = 1;
        stb_q.push_back(int'(bus.rd_flow_num_o));
        stb_cyc = cyc;
      end
      if (bus.out_valid_o) begin
        if (pend) begin
          chk("hold_flow", 64'(bus.out_flow_o), 64'(held.flow));
          chk("hold_data", 64'(bus.out_data_o), 64'(held.data));
          chk("hold_err",  64'(bus.out_err_o),  64'(held.err));
        end else begin
          pend      = 1;
          held.flow = bus.out_flow_o;
          held.data = bus.out_data_o;
          held.err  = bus.out_err_o;
          held.lat  = cyc - stb_cyc;
        end
        if (bus.out_ready_i) begin
          got_q.push_back(held);
          pend = 0;
          outstanding = 0;
        end
      end
      if (bus.done_o) done_cnt++;
    end
  end

  // reference model: flow range modulo 16, values from the responder table
  beat_t         exp_q[$];
  logic [DW+AW-1:0] exp_tot;

  task automatic build_exp(input int f, input int l);
    int n;
    beat_t b;
    exp_q.delete();
    exp_tot = '0;
    n = ((l - f + 16) % 16) + 1;
    for (int i = 0; i < n; i++) begin
      b.flow = 4'((f + i) % 16);
      b.err  = silent[b.flow];
      b.data = silent[b.flow] ? '0 : rdat[b.flow];
      b.lat  = silent[b.flow] ? TO + 1 : dly[b.flow] + 1;
      exp_tot += (DW+AW)'(b.data);
      exp_q.push_back(b);
    end
  endtask

  task automatic default_table();
    for (int i = 0; i < 16; i++) begin
      dly[i]    = 1;
      silent[i] = 0;
      rdat[i]   = DW'(i * 10);
    end
  endtask

  task automatic start_sweep(input int f, input int l);
    got_q.delete();
    stb_q.delete();
    done_cnt = 0;
    @(posedge clk); #1;
    bus.start_i      = 1'b1;
    bus.first_flow_i = 4'(f);
    bus.last_flow_i  = 4'(l);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    @(negedge clk);
    chk("busy_after_start", 64'(bus.busy_o), 64'd1);
  endtask

  task automatic finish_sweep(input string tag, input int f, input int l);
    int n;
    n = 0;
    build_exp(f, l);
    while (done_cnt == 0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, 64'(done_cnt), 64'd1);
    chk({tag, "_busy_low"},  64'(bus.busy_o), 64'd0);
    chk({tag, "_total"},     64'(bus.total_o), 64'(exp_tot));
    chk({tag, "_nbeats"},    64'(got_q.size()), 64'(exp_q.size()));
    chk({tag, "_nstb"},      64'(stb_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s_flow%0d", tag, i), 64'(got_q[i].flow), 64'(exp_q[i].flow));
      chk($sformatf("%s_data%0d", tag, i), 64'(got_q[i].data), 64'(exp_q[i].data));
      chk($sformatf("%s_err%0d",  tag, i), 64'(got_q[i].err),  64'(exp_q[i].err));
      chk($sformatf("%s_lat%0d",  tag, i), 64'(got_q[i].lat),  64'(exp_q[i].lat));
    end
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++)
      chk($sformatf("%s_stb%0d", tag, i), 64'(stb_q[i]), 64'(exp_q[i].flow));
  endtask

  initial begin : main
    int n;
    int f;
    int l;
    default_table();
    rst = 1'b1;
    bus.start_i      = 1'b0;
    bus.first_flow_i = '0;
    bus.last_flow_i  = '0;

    // reset held two cycles
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  64'(bus.busy_o),      64'd0);
    chk("rst_stb",   64'(bus.rd_stb_o),    64'd0);
    chk("rst_flow",  64'(bus.rd_flow_num_o), 64'd0);
    chk("rst_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_oflow", 64'(bus.out_flow_o),  64'd0);
    chk("rst_odata", 64'(bus.out_data_o),  64'd0);
    chk("rst_err",   64'(bus.out_err_o),   64'd0);
    chk("rst_total", 64'(bus.total_o),     64'd0);
    chk("rst_done",  64'(bus.done_o),      64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // basic sweep 3..5
    start_sweep(3, 5);
    finish_sweep("basic", 3, 5);
    chk("basic_total120", 64'(bus.total_o), 64'd120);

    // backpressure on flow 4 with an ignored start in the middle
    rdy_mode = 2;
    hold = 0;
    start_sweep(3, 5);
    n = 0;
    while (!(bus.out_valid_o && bus.out_flow_o == 4'd4) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reached_flow4", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
    bus.start_i      = 1'b1;
    bus.first_flow_i = 4'd9;
    bus.last_flow_i  = 4'd12;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    finish_sweep("bp", 3, 5);
    chk("bp_total120", 64'(bus.total_o), 64'd120);
    chk("bp_stalls", 64'(hold), 64'd4);
    rdy_mode = 0;

    // wrap 14..1
    start_sweep(14, 1);
    finish_sweep("wrap", 14, 1);
    chk("wrap_total300", 64'(bus.total_o), 64'd300);

    // timeout on a silent flow
    silent[7] = 1;
    start_sweep(7, 7);
    finish_sweep("tmo", 7, 7);
    chk("tmo_total0", 64'(bus.total_o), 64'd0);
    silent[7] = 0;

    // reset while waiting on flow 4
    dly[4] = 6;
    start_sweep(3, 5);
    n = 0;
    while (stb_q.size() < 2 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("rstw_reached_flow4", 64'(n < 200), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rstw_busy",  64'(bus.busy_o),      64'd0);
    chk("rstw_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rstw_stb",   64'(bus.rd_stb_o),    64'd0);
    chk("rstw_total", 64'(bus.total_o),     64'd0);
    repeat (20) @(negedge clk);
    chk("rstw_no_done", 64'(done_cnt), 64'd0);
    chk("rstw_idle",    64'(bus.busy_o), 64'd0);
    dly[4] = 1;
    start_sweep(3, 5);
    finish_sweep("rstw_again", 3, 5);
    chk("rstw_total120", 64'(bus.total_o), 64'd120);

    // randomized sweeps
    rdy_mode = 1;
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 16; i++) begin
        dly[i]    = $urandom_range(1, TO);
        silent[i] = ($urandom_range(0, 5) == 0);
        rdat[i]   = $urandom;
      end
      f = $urandom_range(0, 15);
      l = $urandom_range(0, 15);
      start_sweep(f, l);
      finish_sweep($sformatf("rnd%0d", k), f, l);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stat_scanner.md
STAT_SCANNER -- requirements
Module: stat_scanner

Interface
REQ-001 SHALL have parameter A_WIDTH, default 10, flow-number width.
REQ-002 SHALL have parameter D_WIDTH, default 32, counter data width.
REQ-003 SHALL have parameter TIMEOUT, default 15, max WAIT cycles for a read response (1..255).
REQ-004 SHALL have port clk_i  in  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port start_i  in  1  sweep start pulse.
REQ-007 SHALL have port first_flow_i  in  A_WIDTH  first flow of sweep, sampled with start_i.
REQ-008 SHALL have port last_flow_i  in  A_WIDTH  last flow of sweep, sampled with start_i.
REQ-009 SHALL have port busy_o  out  1  high from the cycle after an accepted start until done_o.
REQ-010 SHALL have port rd_stb_o  out  1  read-and-clear strobe to the stats RAM.
REQ-011 SHALL have port rd_flow_num_o  out  A_WIDTH  flow addressed by rd_stb_o.
REQ-012 SHALL have port rd_data_i  in  D_WIDTH  stats RAM read data.
REQ-013 SHALL have port rd_data_val_i  in  1  rd_data_i valid.
REQ-014 SHALL have port out_valid_o  out  1  result beat valid.
REQ-015 SHALL have port out_ready_i  in  1  downstream ready.
REQ-016 SHALL have port out_flow_o  out  A_WIDTH  flow of result beat.
REQ-017 SHALL have port out_data_o  out  D_WIDTH  counter value of result beat.
REQ-018 SHALL have port out_err_o  out  1  beat produced by timeout, data forced 0.
REQ-019 SHALL have port total_o  out  D_WIDTH+A_WIDTH  sum of out_data_o over the current/last sweep.
REQ-020 SHALL have port done_o  out  1  one-cycle pulse, sweep complete.

Function
REQ-021 SHALL implement FSM states IDLE, REQ, WAIT, PUSH, DONE; all outputs registered.
REQ-022 IDLE: start_i=1 -> latch first/last, cur<=first_flow_i, total_o<=0, go REQ; start_i outside IDLE SHALL be ignored.
REQ-023 REQ: rd_stb_o=1 with rd_flow_num_o=cur for exactly one cycle (the cycle after start_i or after the previous handshake); then go WAIT, timer<=0.
REQ-024 WAIT: rd_data_val_i=1 -> capture rd_data_i, out_err_o<=0, go PUSH.
REQ-025 WAIT: no valid and timer reaches TIMEOUT -> data<=0, out_err_o<=1, go PUSH; else timer+1.
REQ-026 rd_data_val_i outside WAIT SHALL be ignored; rd_stb_o SHALL be 0 in every state but REQ.
REQ-027 PUSH: out_valid_o=1; out_flow_o/out_data_o/out_err_o SHALL stay stable until out_ready_i=1.
REQ-028 On handshake (out_valid_o & out_ready_i): total_o += out_data_o; cur==last -> DONE, else cur<=cur+1 mod 2**A_WIDTH, go REQ.
REQ-029 Range wraps: first>last sweeps first..2**A_WIDTH-1, then 0..last; first==last gives one beat.
REQ-030 total_o SHALL be D_WIDTH+A_WIDTH bits, never overflow, and hold its value after DONE until the next start.
REQ-031 DONE: done_o=1 for one cycle, busy_o<=0, go IDLE.
REQ-032 At most one read outstanding; no new rd_stb_o until the previous beat is handshaken.

Reset
REQ-033 rst_i=1 SHALL force IDLE, cur=0, timer=0 and all outputs 0 on the next edge, from any state.
REQ-034 Reset mid-sweep SHALL drop the sweep without a done_o pulse; a start_i after reset SHALL work normally.

Verification (A_WIDTH=4, D_WIDTH=32, TIMEOUT=15; responder returns flow*10 one cycle after rd_stb_o unless stated)
REQ-035 Reset: rst_i high 2 cycles -> all outputs 0, busy_o=0.
REQ-036 start first=3,last=5, ready=1 -> rd_stb_o flows 3,4,5 once each; beats (3,30),(4,40),(5,50), err=0; total_o=120; one done_o pulse.
REQ-037 Backpressure: ready low 4 cycles on flow 4 beat, extra start_i during it -> beat (4,40) stable, no rd_stb_o until handshake, start ignored, total_o=120.
REQ-038 Wrap: first=14,last=1 -> beats for flows 14,15,0,1; total_o=300.
REQ-039 Timeout: responder silent for flow 7, first=last=7 -> PUSH after 15 WAIT cycles, beat (7,0) err=1, total_o=0, done_o pulses.
REQ-040 Reset in WAIT of flow 4 (first=3,last=5) -> IDLE next cycle, no done_o, total_o=0; new start 3..5 repeats REQ-036 results.
